// File: rtl/uart_rx_buf_pkg.sv
// uart_rx_buf_pkg: receiver FSM states and bit-timing derivation shared by the UART buffer
package uart_rx_buf_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  function automatic int half_ticks(input int clk_freq, input int baud);
    return bit_ticks(clk_freq, baud) / 2;
  endfunction
endpackage

// File: rtl/uart_rx_buf_fifo.sv
// rx_fifo: first-word fall-through byte FIFO with wrap-bit pointers
module rx_fifo #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [7:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wp_q, rp_q;
  logic wr, rd;
  always_comb begin
    empty = wp_q == rp_q;
    full  = (wp_q[ADDR_WIDTH] != rp_q[ADDR_WIDTH]) && (wp_q[ADDR_WIDTH-1:0] == rp_q[ADDR_WIDTH-1:0]);
    rd    = pop && !empty;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it
    wr    = push && (!full || rd);
    dout  = mem_q[rp_q[ADDR_WIDTH-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + {{ADDR_WIDTH{1'b0}}, wr};
      rp_q <= rp_q + {{ADDR_WIDTH{1'b0}}, rd};
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wp_q[ADDR_WIDTH-1:0]] <= din;
endmodule

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver feeding a byte FIFO with sticky overflow and frame-error pulse
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       frame_err
);
  localparam int BT = bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int HT = half_ticks(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(BT);
  localparam logic [CW-1:0] BIT_M1  = CW'(BT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [1:0] sync_q;
  logic ferr_q, ferr_d, ovf_q, ovf_d;
  logic rx_s, tick, push;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sync_q  <= 2'b11;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sync_q  <= {sync_q[0], uart_rx};
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = rx_s ? IDLE : START;
      START:     if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_q == 3'd7) state_d = STOP;
      STOP:      if (tick) state_d = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // IDLE keeps the half-bit count preloaded so START times out at mid start bit
  always_comb begin
    cnt_d  = (state_q == IDLE) ? HALF_M1 : tick ? BIT_M1 : cnt_q - CW'(1);
    bit_d  = (state_q != DATA) ? 3'd0 : tick ? bit_q + 3'd1 : bit_q;
    sh_d   = (state_q == DATA && tick) ? {rx_s, sh_q[7:1]} : sh_q;
    push   = state_q == STOP && tick && rx_s;
    ferr_d = state_q == STOP && tick && !rx_s;
    ovf_d  = (push && full && !rd_en) || (ovf_q && !ovf_clr);
  end
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
  rx_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (rd_en),
    .din  (sh_d),
    .dout (dout),
    .empty(empty),
    .full (full)
  );
endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: randomized and directed frames checked against a queue model of the receive buffer
module tb_uart_rx_buf;
  localparam int BIT = 16;
  localparam int HALF = 8;
  localparam int DEPTH = 16;
  localparam int PUSH_AT = 2 + 1 + HALF + 9 * BIT;
  logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, rd_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0] dout;
  logic empty, full, overflow, frame_err;
  int n_chk = 0, n_fail = 0, ferr_total = 0;
  logic [7:0] q[$];
  logic emp_h[160], full_h[160], ovf_h[160], ferr_h[160];
  uart_rx_buf #(.CLK_FREQ(160), .BAUD_RATE(10), .FIFO_ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .dout(dout), .empty(empty),
    .full(full), .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err === 1'b1) ferr_total++;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [7:0] d, input logic sb, input int rd_at, input int clr_at);
    for (int c = 0; c < 160; c++) begin
      emp_h[c] = empty; full_h[c] = full; ovf_h[c] = overflow; ferr_h[c] = frame_err;
      uart_rx = (c < BIT) ? 1'b0 : (c < 9 * BIT) ? d[c / BIT - 1] : sb;
      rd_en = (c == rd_at);
      ovf_clr = (c == clr_at);
      tick(1);
    end
    uart_rx = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_chk += 4;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    tick(5);
  endtask
  task automatic test_single;
    frame(8'h55, 1'b1, -1, -1);
    n_chk += 5;
    if (emp_h[PUSH_AT-1] !== 1'b1) begin n_fail++; $display("FAIL single_early: empty %b expected 1 before push edge", emp_h[PUSH_AT-1]); end
    if (emp_h[PUSH_AT] !== 1'b0) begin n_fail++; $display("FAIL single_push: empty %b expected 0 after push edge", emp_h[PUSH_AT]); end
    if (dout !== 8'h55) begin n_fail++; $display("FAIL single_dout: got %h expected 55", dout); end
    if (ferr_h[PUSH_AT] !== 1'b0) begin n_fail++; $display("FAIL single_ferr: got %b expected 0", ferr_h[PUSH_AT]); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL single_pop: empty %b expected 1", empty); end
  endtask
  task automatic test_frame_err;
    int s = 0;
    frame(8'hA3, 1'b0, -1, -1);
    foreach (ferr_h[c]) s += int'(ferr_h[c]);
    n_chk += 5;
    if (s != 1) begin n_fail++; $display("FAIL ferr_pulse: %0d cycles high expected 1", s); end
    if (ferr_h[PUSH_AT] !== 1'b1) begin n_fail++; $display("FAIL ferr_timing: got %b expected 1 after stop sample", ferr_h[PUSH_AT]); end
    if (empty !== 1'b1) begin n_fail++; $display("FAIL ferr_empty: got %b expected 1", empty); end
    tick(5);
    frame(8'h0F, 1'b1, -1, -1);
    if (empty !== 1'b0) begin n_fail++; $display("FAIL ferr_next_empty: got %b expected 0", empty); end
    if (dout !== 8'h0F) begin n_fail++; $display("FAIL ferr_next_dout: got %h expected 0f", dout); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask
  task automatic test_glitch;
    int f0 = ferr_total;
    uart_rx = 1'b0; tick(4); uart_rx = 1'b1; tick(40);
    n_chk += 4;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b expected 1", empty); end
    if (ferr_total != f0) begin n_fail++; $display("FAIL glitch_ferr: %0d pulses expected 0", ferr_total - f0); end
    frame(8'h81, 1'b1, -1, -1);
    if (empty !== 1'b0) begin n_fail++; $display("FAIL glitch_next_empty: got %b expected 0", empty); end
    if (dout !== 8'h81) begin n_fail++; $display("FAIL glitch_next_dout: got %h expected 81", dout); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask
  task automatic test_overflow;
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      frame(8'(i), 1'b1, -1, -1);
      q.push_back(8'(i));
    end
    n_chk += 5;
    if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", full); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    frame(8'h10, 1'b1, -1, PUSH_AT - 1);
    if (ovf_h[PUSH_AT] !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", ovf_h[PUSH_AT]); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_after: got %b expected 1", full); end
    while (q.size() > 0) begin
      n_chk++;
      if (dout !== q[0] || empty !== 1'b0) begin n_fail++; $display("FAIL ovf_read: dout %h empty %b expected %h and 0", dout, empty, q[0]); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      void'(q.pop_front());
    end
    n_chk += 3;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: empty %b expected 1", empty); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b expected 1", overflow); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask
  task automatic test_full_pop;
    logic [7:0] x;
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      x = 8'($urandom_range(0, 255));
      frame(x, 1'b1, -1, -1);
      q.push_back(x);
    end
    x = 8'($urandom_range(0, 255));
    frame(x, 1'b1, PUSH_AT - 1, -1);
    void'(q.pop_front());
    q.push_back(x);
    n_chk += 3;
    if (ovf_h[PUSH_AT] !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b expected 0", ovf_h[PUSH_AT]); end
    if (full_h[PUSH_AT] !== 1'b1) begin n_fail++; $display("FAIL fullpop_full: got %b expected 1", full_h[PUSH_AT]); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf_after: got %b expected 0", overflow); end
    while (q.size() > 0) begin
      n_chk++;
      if (dout !== q[0] || empty !== 1'b0) begin n_fail++; $display("FAIL fullpop_read: dout %h empty %b expected %h and 0", dout, empty, q[0]); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      void'(q.pop_front());
    end
  endtask
  task automatic test_reset_mid;
    for (int c = 0; c < 86; c++) begin
      uart_rx = (c < BIT) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst = 1'b1; uart_rx = 1'b1; tick(3); rst = 1'b0; tick(10);
    n_chk += 4;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 1", empty); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL rstmid_full: got %b expected 0", full); end
    frame(8'h3C, 1'b1, -1, -1);
    if (empty !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_empty: got %b expected 0", empty); end
    if (dout !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next_dout: got %h expected 3c", dout); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask
  task automatic test_random;
    logic [7:0] d;
    logic sb, movf = 1'b0;
    int bad = 0, f0 = ferr_total, k;
    q.delete();
    for (int i = 0; i < 14; i++) begin
      d = 8'($urandom_range(0, 255));
      sb = $urandom_range(0, 3) != 0;
      frame(d, sb, -1, -1);
      if (!sb) bad++;
      else if (q.size() < DEPTH) q.push_back(d);
      else movf = 1'b1;
      tick($urandom_range(4, 10));
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        if (q.size() > 0) begin
          n_chk++;
          if (dout !== q[0] || empty !== 1'b0) begin n_fail++; $display("FAIL rand_read: dout %h empty %b expected %h and 0", dout, empty, q[0]); end
          rd_en = 1'b1; tick(1); rd_en = 1'b0;
          void'(q.pop_front());
        end
      end
    end
    n_chk += 2;
    if (ferr_total - f0 != bad) begin n_fail++; $display("FAIL rand_ferr: %0d pulses expected %0d", ferr_total - f0, bad); end
    if (overflow !== movf) begin n_fail++; $display("FAIL rand_ovf: got %b expected %b", overflow, movf); end
    while (q.size() > 0) begin
      n_chk++;
      if (dout !== q[0] || empty !== 1'b0) begin n_fail++; $display("FAIL rand_drain: dout %h empty %b expected %h and 0", dout, empty, q[0]); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      void'(q.pop_front());
    end
    n_chk++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL rand_empty: got %b expected 1", empty); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_frame_err();
    test_glitch();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
